mult_div_unit: RTL

- Iterative multiply/divide unit on the ALU side of the execute stage.
- Consumes the selected 32-bit operand pair (op1 from rs, op2 after operand selection) and produces HI/LO results for MULT/MULTU/DIV/DIVU.
- Provides direct HI/LO writes for MTHI/MTLO and a start/busy/done handshake so the pipeline controller can stall until results are valid.

---
 rtl/mult_div_unit.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Iterative multiply/divide unit for the execute stage. It produces HI/LO
// results for MULT, MULTU, DIV and DIVU using one radix-2 step per cycle.
// MTHI/MTLO can write HI/LO directly. A start/busy/done handshake lets the
// pipeline controller stall until the results are valid.
//
// Parameters
//   WIDTH  operand width; one operation takes WIDTH iterations
//   CNT_W  iteration counter width; must be able to hold WIDTH-1
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     operation request, sampled only while busy=0
//   op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   op1       multiplicand / dividend (must be valid only with an accepted start)
//   op2       multiplier / divisor    (must be valid only with an accepted start)
//   hi_we     MTHI write strobe (idle only, start has priority)
//   lo_we     MTLO write strobe (idle only, start has priority)
//   wdata     MTHI/MTLO write data
//   busy      operation in progress (RUN or FIX)
//   done      one-cycle pulse: hi/lo were just updated by an operation
//   hi, lo    HI and LO result registers
//   div_zero  present only when MDU_DIVZERO_FLAG_EN is defined; high in the
//             done cycle of a DIV/DIVU whose divisor was zero
//
// Optional feature macro: MDU_DIVZERO_FLAG_EN
// -----------------------------------------------------------------------------
module mult_div_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
`ifdef MDU_DIVZERO_FLAG_EN
   ,
   output logic             div_zero
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } state_e;

   state_e             state_q;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   a_q;       // |op1| for signed ops, raw op1 otherwise
   logic [WIDTH-1:0]   b_q;       // |op2| for signed ops, raw op2 otherwise
   logic               s1_q;
   logic               s2_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH-1:0] acc_q;     // product, or {remainder, dividend/quotient}
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
`ifdef MDU_DIVZERO_FLAG_EN
   logic               dz_q;
`endif

   // Operand conditioning at start
   logic               in_signed;
   logic [WIDTH-1:0]   a_in;
   logic [WIDTH-1:0]   b_in;

   // Iteration datapath
   logic               is_div;
   logic               is_signed;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_r;
   logic [WIDTH:0]     div_diff;
   logic               div_ok;
   logic [2*WIDTH-1:0] acc_d;

   // Sign correction / result formation
   logic [2*WIDTH-1:0] mul_res;
   logic [WIDTH-1:0]   quo_res;
   logic [WIDTH-1:0]   rem_res;
   logic [WIDTH-1:0]   op1_raw;
   logic               div_by_zero;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   always_comb begin
      in_signed = ~op[0];
      a_in      = (in_signed && op1[WIDTH-1]) ? -op1 : op1;
      b_in      = (in_signed && op2[WIDTH-1]) ? -op2 : op2;
   end

   always_comb begin
      is_div    = op_q[1];
      is_signed = ~op_q[0];

      // Multiply: add the multiplier into the upper half when the current LSB
      // is set, then shift the whole product right by one. The carry out of
      // the add becomes the new MSB.
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                (acc_q[0] ? {1'b0, b_q} : '0);

      // Restoring divide: shift the next dividend bit into the partial
      // remainder and try to subtract the divisor. A clear borrow bit means
      // the subtraction fits and the quotient bit is 1. The partial remainder
      // always stays below 2*divisor, so WIDTH+1 bits are enough.
      div_r    = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff = div_r - {1'b0, b_q};
      div_ok   = ~div_diff[WIDTH];

      if (is_div) begin
         acc_d = {(div_ok ? div_diff[WIDTH-1:0] : div_r[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], div_ok};
      end else begin
         acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      mul_res     = (is_signed && (s1_q ^ s2_q)) ? -acc_q : acc_q;
      quo_res     = (is_signed && (s1_q ^ s2_q)) ? -acc_q[WIDTH-1:0]
                                                 : acc_q[WIDTH-1:0];
      rem_res     = (is_signed && s1_q) ? -acc_q[2*WIDTH-1:WIDTH]
                                        : acc_q[2*WIDTH-1:WIDTH];
      // Negating the stored magnitude gives back the original dividend. This
      // also holds for the most negative value, which maps to itself.
      op1_raw     = (is_signed && s1_q) ? -a_q : a_q;
      div_by_zero = (b_q == '0);

      if (is_div) begin
         if (div_by_zero) begin
            fix_hi = op1_raw;
            fix_lo = '1;
         end else begin
            fix_hi = rem_res;
            fix_lo = quo_res;
         end
      end else begin
         fix_hi = mul_res[2*WIDTH-1:WIDTH];
         fix_lo = mul_res[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
`ifdef MDU_DIVZERO_FLAG_EN
         dz_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
`ifdef MDU_DIVZERO_FLAG_EN
               dz_q   <= 1'b0;
`endif
               if (start) begin
                  // An accepted start takes priority over MTHI/MTLO strobes
                  // in the same cycle, so those writes are dropped.
                  op_q    <= op;
                  a_q     <= a_in;
                  b_q     <= b_in;
                  s1_q    <= op1[WIDTH-1];
                  s2_q    <= op2[WIDTH-1];
                  cnt_q   <= CNT_W'(WIDTH - 1);
                  acc_q   <= {{WIDTH{1'b0}}, a_in};
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end else begin
                  state_q <= S_IDLE;
                  if (hi_we) hi_q <= wdata;
                  if (lo_we) lo_q <= wdata;
               end
            end

            S_RUN: begin
               acc_q <= acc_d;
               if (cnt_q == '0) begin
                  state_q <= S_FIX;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end

            S_FIX: begin
               hi_q    <= fix_hi;
               lo_q    <= fix_lo;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
`ifdef MDU_DIVZERO_FLAG_EN
               dz_q    <= is_div && div_by_zero;
`endif
               state_q <= S_DONE;
            end

            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
`ifdef MDU_DIVZERO_FLAG_EN
   assign div_zero = dz_q;
`endif

endmodule
